// File: rtl/dunc16_memctl.sv
// Single-port CPU memory controller: RAM accesses with ACK handshake and
// 16-cycle timeout, plus one memory-mapped I/O register at 16'hFFFF.
module dunc16_memctl (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        REQ,
   input  logic        WE,
   input  logic [15:0] ADDRESS,
   input  logic [15:0] MD_OUT,
   output logic [15:0] MMO,
   output logic        DONE,
   output logic        BUSY,
   output logic        ERR,
   output logic        RAM_CS,
   output logic        RAM_WE,
   output logic [15:0] RAM_ADDR,
   output logic [15:0] RAM_WDATA,
   input  logic [15:0] RAM_RDATA,
   input  logic        RAM_ACK,
   input  logic [15:0] IO_IN,
   output logic [15:0] IO_OUT
);

   localparam int unsigned DW = 16;
   localparam int unsigned TW = 4;
   localparam logic [DW-1:0] IO_ADDR  = 16'hFFFF;
   localparam logic [DW-1:0] TMO_DATA = 16'hFFFF;
   localparam logic [TW-1:0] TMO_MAX  = 4'hF;

   typedef enum logic [1:0] {IDLE, IO, ACCESS, FINISH} state_t;

   state_t          state, state_next;
   logic            we_q, we_next;
   logic [TW-1:0]   tmo, tmo_next;
   logic [DW-1:0]   addr_next, wdata_next, mmo_next, io_out_next;
   logic            err_next;

   // State register
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) state <= IDLE;
      else       state <= state_next;
   end

   // Next state and next datapath values
   always_comb begin
      state_next  = state;
      we_next     = we_q;
      addr_next   = RAM_ADDR;
      wdata_next  = RAM_WDATA;
      mmo_next    = MMO;
      io_out_next = IO_OUT;
      err_next    = ERR;
      tmo_next    = tmo;
      case (state)
         IDLE: begin
            if (REQ) begin
               we_next    = WE;
               addr_next  = ADDRESS;
               wdata_next = MD_OUT;
               tmo_next   = '0;
               state_next = (ADDRESS == IO_ADDR) ? IO : ACCESS;
            end
         end
         IO: begin
            if (we_q) io_out_next = RAM_WDATA;
            else      mmo_next    = IO_IN;
            state_next = FINISH;
         end
         ACCESS: begin
            // An ACK on the last allowed cycle still wins over the timeout
            if (RAM_ACK) begin
               if (!we_q) mmo_next = RAM_RDATA;
               state_next = FINISH;
            end else if (tmo == TMO_MAX) begin
               err_next = 1'b1;
               if (!we_q) mmo_next = TMO_DATA;
               state_next = FINISH;
            end else begin
               tmo_next = tmo + TW'(1);
            end
         end
         FINISH: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Datapath and output registers; strobes are registered from the next state
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         we_q      <= 1'b0;
         tmo       <= '0;
         RAM_ADDR  <= '0;
         RAM_WDATA <= '0;
         MMO       <= '0;
         IO_OUT    <= '0;
         ERR       <= 1'b0;
         DONE      <= 1'b0;
         BUSY      <= 1'b0;
         RAM_CS    <= 1'b0;
         RAM_WE    <= 1'b0;
      end else begin
         we_q      <= we_next;
         tmo       <= tmo_next;
         RAM_ADDR  <= addr_next;
         RAM_WDATA <= wdata_next;
         MMO       <= mmo_next;
         IO_OUT    <= io_out_next;
         ERR       <= err_next;
         DONE      <= (state_next == FINISH);
         BUSY      <= (state_next != IDLE);
         RAM_CS    <= (state_next == ACCESS);
         RAM_WE    <= (state_next == ACCESS) && we_next;
      end
   end

endmodule

// File: tb/tb_dunc16_memctl.sv
// Directed bench for dunc16_memctl: vector table of single accesses plus
// hand-written sequences for busy REQ, stray ACK and mid-access reset.
module tb_dunc16_memctl;

   logic        CLK = 1'b0;
   logic        RESET = 1'b1;
   logic        REQ = 1'b0;
   logic        WE = 1'b0;
   logic [15:0] ADDRESS = '0;
   logic [15:0] MD_OUT = '0;
   logic [15:0] MMO;
   logic        DONE, BUSY, ERR, RAM_CS, RAM_WE;
   logic [15:0] RAM_ADDR, RAM_WDATA;
   logic [15:0] RAM_RDATA = '0;
   logic        RAM_ACK = 1'b0;
   logic [15:0] IO_IN = '0;
   logic [15:0] IO_OUT;

   int n_cmp = 0;
   int n_bad = 0;

   dunc16_memctl dut (
      .CLK(CLK), .RESET(RESET), .REQ(REQ), .WE(WE), .ADDRESS(ADDRESS),
      .MD_OUT(MD_OUT), .MMO(MMO), .DONE(DONE), .BUSY(BUSY), .ERR(ERR),
      .RAM_CS(RAM_CS), .RAM_WE(RAM_WE), .RAM_ADDR(RAM_ADDR),
      .RAM_WDATA(RAM_WDATA), .RAM_RDATA(RAM_RDATA), .RAM_ACK(RAM_ACK),
      .IO_IN(IO_IN), .IO_OUT(IO_OUT)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic        we;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] io_in;
      logic [15:0] rdata;
      int          ack_at;   // ACCESS cycle (1-based) that gets RAM_ACK; 0 = never
      int          exp_lat;
      int          exp_cs;
      logic [15:0] exp_mmo;
      logic [15:0] exp_io_out;
      logic        exp_err;
   } vec_t;

   vec_t vecs[9];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      int   cyc = 0;
      int   cs = 0;
      int   lat = 0;
      logic hold_ok = 1'b1;
      REQ = 1'b1; WE = v.we; ADDRESS = v.addr; MD_OUT = v.wdata;
      RAM_RDATA = v.rdata; IO_IN = v.io_in; RAM_ACK = 1'b0;
      while (lat == 0 && cyc < 40) begin
         @(negedge CLK);
         REQ = 1'b0;
         cyc++;
         RAM_ACK = 1'b0;
         if (RAM_CS) begin
            cs++;
            if (RAM_ADDR !== v.addr || RAM_WE !== v.we || (v.we && RAM_WDATA !== v.wdata))
               hold_ok = 1'b0;
            if (cs == v.ack_at) RAM_ACK = 1'b1;
         end
         if (DONE) lat = cyc;
      end
      RAM_ACK = 1'b0;
      chk($sformatf("v%0d latency", idx), 32'(lat), 32'(v.exp_lat));
      chk($sformatf("v%0d cs_cycles", idx), 32'(cs), 32'(v.exp_cs));
      chk($sformatf("v%0d ram_hold", idx), 32'(hold_ok), 32'd1);
      chk($sformatf("v%0d mmo", idx), 32'(MMO), 32'(v.exp_mmo));
      chk($sformatf("v%0d io_out", idx), 32'(IO_OUT), 32'(v.exp_io_out));
      chk($sformatf("v%0d err", idx), 32'(ERR), 32'(v.exp_err));
      @(negedge CLK);
      chk($sformatf("v%0d done_once", idx), 32'({DONE, BUSY}), 32'd0);
   endtask

   initial begin
      int dones;
      int lat;
      //            we    addr      wdata     io_in     rdata    ack lat cs  mmo       io_out    err
      vecs[0] = '{1'b0, 16'h0010, 16'h0000, 16'h0000, 16'h1234, 1,  2,  1, 16'h1234, 16'h0000, 1'b0};
      vecs[1] = '{1'b1, 16'h0020, 16'hBEEF, 16'h0000, 16'h9999, 4,  5,  4, 16'h1234, 16'h0000, 1'b0};
      vecs[2] = '{1'b1, 16'hFFFF, 16'h00A5, 16'h0000, 16'h0000, 1,  2,  0, 16'h1234, 16'h00A5, 1'b0};
      vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h5A5A, 16'h0000, 1,  2,  0, 16'h5A5A, 16'h00A5, 1'b0};
      vecs[4] = '{1'b0, 16'hFFFE, 16'h0000, 16'h1111, 16'h7777, 2,  3,  2, 16'h7777, 16'h00A5, 1'b0};
      vecs[5] = '{1'b0, 16'h0040, 16'h0000, 16'h0000, 16'h0BCD, 16, 17, 16, 16'h0BCD, 16'h00A5, 1'b0};
      vecs[6] = '{1'b0, 16'h0030, 16'h0000, 16'h0000, 16'h2222, 0,  17, 16, 16'hFFFF, 16'h00A5, 1'b1};
      vecs[7] = '{1'b0, 16'h0060, 16'h0000, 16'h0000, 16'h4321, 1,  2,  1, 16'h4321, 16'h00A5, 1'b1};
      vecs[8] = '{1'b1, 16'h0050, 16'hCAFE, 16'h0000, 16'h3333, 0,  17, 16, 16'h4321, 16'h00A5, 1'b1};

      // Reset state
      repeat (2) @(negedge CLK);
      chk("reset_outs", 32'({DONE, BUSY, ERR, RAM_CS, RAM_WE}), 32'd0);
      chk("reset_mmo_io", {MMO, IO_OUT}, 32'd0);
      chk("reset_ram_bus", {RAM_ADDR, RAM_WDATA}, 32'd0);
      RESET = 1'b0;

      for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

      // REQ while busy (in ACCESS and in FINISH) must be dropped
      REQ = 1'b1; WE = 1'b0; ADDRESS = 16'h0070; RAM_RDATA = 16'h1111;
      dones = 0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         REQ = (c == 1 || c == 2 || c == 4);
         WE = 1'b1; ADDRESS = 16'hFFFF; MD_OUT = 16'hDEAD;
         RAM_ACK = RAM_CS && (c == 3);
         if (DONE) dones++;
      end
      REQ = 1'b0; RAM_ACK = 1'b0;
      chk("busy_one_done", 32'(dones), 32'd1);
      chk("busy_mmo", 32'(MMO), 32'h1111);
      chk("busy_io_out", 32'(IO_OUT), 32'h00A5);
      chk("busy_idle", 32'(BUSY), 32'd0);

      // Stray RAM_ACK while idle
      RAM_ACK = 1'b1; RAM_RDATA = 16'h5555;
      dones = 0;
      repeat (3) begin
         @(negedge CLK);
         if (DONE || BUSY) dones++;
      end
      RAM_ACK = 1'b0;
      chk("stray_ack_quiet", 32'(dones), 32'd0);
      chk("stray_ack_mmo", 32'(MMO), 32'h1111);

      // Reset mid-ACCESS, then REQ on the first edge after release
      REQ = 1'b1; WE = 1'b1; ADDRESS = 16'h0080; MD_OUT = 16'h1357;
      @(negedge CLK); REQ = 1'b0;
      @(negedge CLK);
      chk("pre_reset_cs", 32'({RAM_CS, BUSY}), 32'd3);
      RESET = 1'b1;
      #1;
      chk("mid_reset_flags", 32'({DONE, BUSY, ERR, RAM_CS, RAM_WE}), 32'd0);
      chk("mid_reset_data", {MMO, IO_OUT}, 32'd0);
      chk("mid_reset_bus", {RAM_ADDR, RAM_WDATA}, 32'd0);
      dones = 0;
      repeat (2) begin
         @(negedge CLK);
         if (DONE) dones++;
      end
      RESET = 1'b0;
      REQ = 1'b1; WE = 1'b0; ADDRESS = 16'hFFFF; IO_IN = 16'h0F0F;
      lat = 0;
      for (int c = 1; c <= 6 && lat == 0; c++) begin
         @(negedge CLK);
         REQ = 1'b0;
         if (DONE) lat = c;
      end
      chk("reset_no_done", 32'(dones), 32'd0);
      chk("post_reset_lat", 32'(lat), 32'd2);
      chk("post_reset_mmo", 32'(MMO), 32'h0F0F);
      chk("post_reset_err", 32'(ERR), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/dunc16_memctl.md
DUNC16_MEMCTL -- requirements
Module: dunc16_memctl

Interface
REQ-001 The block SHALL have exactly one clock, CLK, and an asynchronous active-high reset, RESET; all state SHALL update on the rising edge of CLK.
REQ-002 The ports SHALL be, one per line, name direction width meaning:
- CLK  in  1  system clock
- RESET  in  1  asynchronous active-high reset
- REQ  in  1  CPU access request, one-cycle pulse
- WE  in  1  1 = write, 0 = read; qualified by REQ
- ADDRESS  in  16  CPU word address; qualified by REQ
- MD_OUT  in  16  CPU write data; qualified by REQ
- MMO  out  16  read-data register returned to the CPU
- DONE  out  1  one-cycle completion pulse
- BUSY  out  1  access in progress
- ERR  out  1  sticky timeout flag
- RAM_CS  out  1  external RAM select
- RAM_WE  out  1  external RAM write strobe
- RAM_ADDR  out  16  external RAM address
- RAM_WDATA  out  16  external RAM write data
- RAM_RDATA  in  16  external RAM read data
- RAM_ACK  in  1  external RAM completion
- IO_IN  in  16  input port, read at 16'hFFFF
- IO_OUT  out  16  output port, written at 16'hFFFF
REQ-003 All outputs SHALL be driven from registers or decoded from registered state only, with no combinational path from any input.

Function
REQ-004 The state machine SHALL have exactly four states: IDLE, IO, ACCESS and FINISH.
REQ-005 In IDLE, REQ=1 SHALL latch WE, ADDRESS and MD_OUT into internal registers.
REQ-006 From IDLE on REQ=1, the next state SHALL be IO if ADDRESS=16'hFFFF and ACCESS otherwise.
REQ-007 REQ asserted in any state other than IDLE SHALL be ignored, with no latch and no queueing.
REQ-008 In IO for one cycle: a write SHALL load IO_OUT with the latched data; a read SHALL load MMO with IO_IN; then the next state SHALL be FINISH.
REQ-009 During IO, RAM_CS SHALL stay 0.
REQ-010 In ACCESS: RAM_CS=1, RAM_ADDR=latched address, RAM_WE=latched WE, RAM_WDATA=latched data; these SHALL be held stable until the state exits.
REQ-011 In ACCESS, RAM_ACK=1 SHALL load MMO with RAM_RDATA on a read (MMO unchanged on a write) and move to FINISH.
REQ-012 A 4-bit timeout counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without RAM_ACK.
REQ-013 If the timeout counter reaches 15 with no RAM_ACK, the block SHALL set ERR, load MMO with 16'hFFFF on a read, and move to FINISH (16 ACCESS cycles maximum).
REQ-014 RAM_ACK=1 in the same cycle the timeout counter reaches 15 SHALL be treated as success: ERR unchanged and real data loaded.
REQ-015 In FINISH, DONE=1 for exactly one cycle, then the next state SHALL be IDLE; a new REQ SHALL be accepted from the following cycle.
REQ-016 BUSY SHALL be 1 in IO, ACCESS and FINISH, and 0 in IDLE.
REQ-017 ERR SHALL be sticky and cleared only by RESET.
REQ-018 RAM_ACK outside ACCESS SHALL be ignored.
REQ-019 Latency from a REQ cycle to DONE SHALL be 2 cycles for an IO access, and 2 to 17 cycles for a RAM access, 2 being a RAM_ACK in the first ACCESS cycle.
REQ-020 The address comparison SHALL be a full 16-bit compare, with no aliasing of 16'hFFFF.

Reset
REQ-021 RESET=1 SHALL immediately force state=IDLE; MMO, IO_OUT, RAM_ADDR and RAM_WDATA to 16'h0000; DONE, BUSY, ERR, RAM_CS, RAM_WE and the timeout counter to 0.
REQ-022 RESET asserted during ACCESS or FINISH SHALL abort the access with no DONE pulse, and RAM_CS SHALL drop asynchronously.
REQ-023 After RESET deasserts, the first rising edge SHALL sample REQ normally.

Verification
REQ-024 Read, RAM_ACK in the first ACCESS cycle: REQ,WE=0,ADDRESS=16'h0010 with RAM_RDATA=16'h1234 -> RAM_CS for 1 cycle, DONE at REQ+2, MMO=16'h1234, ERR=0.
REQ-025 Write with 3 wait cycles: REQ,WE=1,ADDRESS=16'h0020,MD_OUT=16'hBEEF, RAM_ACK in the 4th ACCESS cycle -> RAM_WE=1 and RAM_WDATA=16'hBEEF for 4 cycles, DONE at REQ+5, MMO unchanged.
REQ-026 IO port: write 16'h00A5 to 16'hFFFF, then read with IO_IN=16'h5A5A -> IO_OUT=16'h00A5, MMO=16'h5A5A, RAM_CS never 1, each DONE at REQ+2.
REQ-027 Timeout: read of 16'h0030 with RAM_ACK held 0 -> 16 RAM_CS cycles, DONE at REQ+17, MMO=16'hFFFF, ERR=1; the next successful read leaves ERR=1.
REQ-028 REQ pulsed while BUSY=1 -> ignored, and exactly one DONE per accepted request.
REQ-029 RESET mid-ACCESS -> RAM_CS=0 and BUSY=0 immediately, no DONE, all outputs at REQ-021 values.
